mc_ctrl_fsm: RTL

//  Multicycle control FSM for the MIPS-lite core. It sequences the single shared ALU, PC, IR,

---
 rtl/mc_ctrl_fsm_pkg.sv | 61 ++++++
 rtl/mc_ctrl_fsm_alu_dec.sv | 22 ++
 rtl/mc_ctrl_fsm.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the MIPS-lite multicycle controller: state codes, opcode/funct
// constants, ALU control codes and datapath select values.
package mc_ctrl_fsm_pkg;

  localparam int ALU_OP_LENGTH = 3;

  localparam logic [ALU_OP_LENGTH-1:0] ALU_CONLROL_ADDU = 3'd0;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_CONLROL_ADD  = 3'd1;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_CONLROL_SUBU = 3'd2;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_CONLROL_ORI  = 3'd3;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] SRC_B_BR   = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_t;

  // S_FETCH doubles as the "illegal encoding" answer since DECODE never returns there otherwise.
  function automatic state_t decode_target(input logic [5:0] opcode, input logic funct_legal);
    state_t s;
    s = S_FETCH;
    case (opcode)
      OP_RTYPE:     if (funct_legal) s = S_EXEC_R;
      OP_ORI:       s = S_EXEC_I;
      OP_LW, OP_SW: s = S_MEM_ADDR;
      OP_BEQ:       s = S_BRANCH;
      OP_J:         s = S_JUMP;
      default:      s = S_FETCH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// R-type funct decoder: maps funct to an ALU control code and flags unsupported functs.
// Kept standalone so a pipelined decoder can reuse it.
module mc_alu_dec
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0]               funct,
  output logic [ALU_OP_LENGTH-1:0] alu_op,
  output logic                     legal
);

  always_comb begin
    alu_op = ALU_CONLROL_ADDU;
    legal  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_CONLROL_ADD;
      FN_ADDU: alu_op = ALU_CONLROL_ADDU;
      FN_SUBU: alu_op = ALU_CONLROL_SUBU;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM for the MIPS-lite core (add/addu/subu/ori/lw/sw/beq/j).
// Optional feature: define OVERFLOW_TRAP_EN to trap signed-add overflow on 'add'.
//
// state      | meaning
// S_FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
// S_DECODE   | decode IR, precompute branch target into ALUOut
// S_EXEC_R   | regA op regB for R-type
// S_EXEC_I   | regA | zext(imm) for ori
// S_MEM_ADDR | regA + sext(imm) effective address
// S_MEM_RD   | load from ALUOut, wait for memory
// S_MEM_WR   | store to ALUOut, wait for memory
// S_WB_ALU   | write ALUOut to rd/rt
// S_WB_MEM   | write MDR to rt
// S_BRANCH   | compare regA-regB, take ALUOut target on zero
// S_JUMP     | load PC with jump target
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [5:0]               opcode,
  input  logic [5:0]               funct,
  input  logic                     zero,
  input  logic                     alu_ovf,
  input  logic                     mem_ready,
  output logic                     pc_we,
  output logic                     ir_we,
  output logic                     mem_rd,
  output logic                     mem_we,
  output logic                     iord,
  output logic                     reg_we,
  output logic                     reg_dst,
  output logic                     mem_to_reg,
  output logic                     alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic                     ext_zero,
  output logic [1:0]               pc_src,
  output logic [ALU_OP_LENGTH-1:0] alu_op,
  output logic                     instr_done,
  output logic                     illegal_op
);

  state_t                   state_q, state_d;
  logic                     reg_dst_q, reg_dst_d;
  logic [ALU_OP_LENGTH-1:0] funct_alu_op;
  logic                     funct_legal;
  state_t                   dec_target;
  logic                     dec_illegal;
  logic                     ovf_trap;

  mc_alu_dec u_alu_dec (
    .funct  (funct),
    .alu_op (funct_alu_op),
    .legal  (funct_legal)
  );

  assign dec_target  = decode_target(opcode, funct_legal);
  assign dec_illegal = (dec_target == S_FETCH);

`ifdef OVERFLOW_TRAP_EN
  assign ovf_trap = (funct == FN_ADD) && alu_ovf;
`else
  logic unused_alu_ovf;
  assign unused_alu_ovf = alu_ovf;
  assign ovf_trap       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      reg_dst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reg_dst_q <= reg_dst_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    reg_dst_d = reg_dst_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d   = dec_target;
        reg_dst_d = (opcode == OP_RTYPE);
      end
      S_EXEC_R:   state_d = ovf_trap ? S_FETCH : S_WB_ALU;
      S_EXEC_I:   state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_rd     = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    ext_zero   = 1'b0;
    pc_src     = PC_SRC_ALU;
    alu_op     = ALU_CONLROL_ADDU;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRC_B_BR;
        illegal_op = dec_illegal;
        instr_done = dec_illegal;
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = funct_alu_op;
        illegal_op = ovf_trap;
        instr_done = ovf_trap;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        ext_zero  = 1'b1;
        alu_op    = ALU_CONLROL_ORI;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
      end
      S_MEM_WR: begin
        mem_we     = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_WB_ALU: begin
        reg_we     = 1'b1;
        reg_dst    = reg_dst_q;
        instr_done = 1'b1;
      end
      S_WB_MEM: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_CONLROL_SUBU;
        pc_src     = PC_SRC_ALUOUT;
        pc_we      = zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_we      = 1'b1;
        pc_src     = PC_SRC_JUMP;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Outputs are combinational from state, so reset must mask them directly.
    if (!rst_n) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mem_rd     = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRC_B_REG;
      ext_zero   = 1'b0;
      pc_src     = PC_SRC_ALU;
      alu_op     = ALU_CONLROL_ADDU;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule
